// File: rtl/rv_pkg.sv
// Shared types and sizing for the integer register file and its busy scoreboard.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;
  typedef logic [NREG-1:0] busy_vec_t;

  localparam reg_idx_t REG_ZERO = '0;

  function automatic busy_vec_t idx_onehot(input reg_idx_t idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: read ports, write port and issue/hazard pair.
interface regfile_sb_if;
  import rv_pkg::*;

  // Issue handshake: issue_valid is the request and !hazard the ready. An instruction
  // issues on the rising edge where issue_valid=1 and hazard=0; while hazard=1 decode
  // holds the same instruction and nothing is recorded.
  logic      regwrite;
  reg_idx_t  rd;
  xdata_t    rd_data;
  reg_idx_t  rs1;
  reg_idx_t  rs2;
  xdata_t    rs1_data;
  xdata_t    rs2_data;
  logic      issue_valid;
  logic      issue_wr;
  reg_idx_t  issue_rd;
  logic      flush;
  logic      hazard;
  busy_vec_t busy;

  modport master (
    output regwrite, rd, rd_data, rs1, rs2, issue_valid, issue_wr, issue_rd, flush,
    input  rs1_data, rs2_data, hazard, busy
  );

  modport slave (
    input  regwrite, rd, rd_data, rs1, rs2, issue_valid, issue_wr, issue_rd, flush,
    output rs1_data, rs2_data, hazard, busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight long-latency producers, plus RAW/WAW hazard detect.
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      regwrite,
  input  reg_idx_t  rd,
  input  reg_idx_t  rs1,
  input  reg_idx_t  rs2,
  input  logic      issue_valid,
  input  logic      issue_wr,
  input  reg_idx_t  issue_rd,
  input  logic      flush,
  output logic      hazard,
  output busy_vec_t busy
);

  busy_vec_t busy_q;
  busy_vec_t busy_d;
  busy_vec_t clr_mask;
  busy_vec_t set_mask;
  logic      pend_rs1;
  logic      pend_rs2;
  logic      pend_ird;
  logic      issue_fire;

  // A writeback landing this cycle resolves the dependency via the bypass path.
  always_comb begin
    pend_rs1 = busy_q[rs1]      && !(regwrite && (rd == rs1));
    pend_rs2 = busy_q[rs2]      && !(regwrite && (rd == rs2));
    pend_ird = busy_q[issue_rd] && !(regwrite && (rd == issue_rd));
    hazard   = issue_valid && !flush &&
               (pend_rs1 || pend_rs2 || (issue_wr && (issue_rd != REG_ZERO) && pend_ird));
    issue_fire = issue_valid && issue_wr && !hazard && (issue_rd != REG_ZERO);
  end

  // Set is applied after clear so a new producer wins; flush overrides everything.
  always_comb begin
    clr_mask = regwrite   ? idx_onehot(rd)       : '0;
    set_mask = issue_fire ? idx_onehot(issue_rd) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W integer register file with write-first bypass, hardwired x0 and busy scoreboard.
module regfile_sb
  import rv_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  xdata_t regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.regwrite && (bus.rd != REG_ZERO)) begin
      regs_q[bus.rd] <= bus.rd_data;
    end
  end

  // Write-first: a same-cycle writeback to the read index is visible immediately.
  function automatic xdata_t read_port(input reg_idx_t idx);
    if (idx == REG_ZERO)                     return '0;
    else if (bus.regwrite && (bus.rd == idx)) return bus.rd_data;
    else                                      return regs_q[idx];
  endfunction

  always_comb begin
    bus.rs1_data = read_port(bus.rs1);
    bus.rs2_data = read_port(bus.rs2);
  end

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .regwrite    (bus.regwrite),
    .rd          (bus.rd),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .issue_valid (bus.issue_valid),
    .issue_wr    (bus.issue_wr),
    .issue_rd    (bus.issue_rd),
    .flush       (bus.flush),
    .hazard      (bus.hazard),
    .busy        (bus.busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, mid-cycle reset sequence, random vs model.
module tb_regfile_sb;
  import rv_pkg::*;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        iv;
    logic        iw;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh;
    logic [31:0] eb;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.regwrite && bus.rd == idx) return bus.rd_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_pend(input logic [4:0] idx);
    return m_busy[idx] && !(bus.regwrite && bus.rd == idx);
  endfunction

  function automatic bit m_hazard();
    if (!bus.issue_valid || bus.flush) return 1'b0;
    return m_pend(bus.rs1) || m_pend(bus.rs2) ||
           (bus.issue_wr && bus.issue_rd != 0 && m_pend(bus.issue_rd));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Called just after the edge while the pre-edge inputs are still held.
  function automatic void m_commit();
    bit h;
    h = m_hazard();
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (bus.regwrite) m_busy[bus.rd] = 1'b0;
      if (bus.issue_valid && bus.issue_wr && !h && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    if (bus.regwrite && bus.rd != 0) m_regs[bus.rd] = bus.rd_data;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    bus.regwrite    = v.wr;
    bus.rd          = v.rd;
    bus.rd_data     = v.wd;
    bus.rs1         = v.r1;
    bus.rs2         = v.r2;
    bus.issue_valid = v.iv;
    bus.issue_wr    = v.iw;
    bus.issue_rd    = v.ird;
    bus.flush       = v.fl;
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] rd, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic iv, input logic iw, input logic [4:0] ird,
                              input logic fl, input logic [31:0] e1, input logic [31:0] e2,
                              input logic eh, input logic [31:0] eb);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.iv = iv; v.iw = iw; v.ird = ird; v.fl = fl;
    v.e1 = e1; v.e2 = e2; v.eh = eh; v.eb = eb;
    return v;
  endfunction

  vec_t vt [19];

  initial begin
    vec_t rv;
    n_vec = 0;
    n_bad = 0;
    m_reset();

    // Expected busy in each row is the value seen during that cycle, before its edge.
    //             wr rd  wd             r1 r2 iv iw ird fl  e1             e2             eh  eb
    vt[0]  = mk(1, 5,  32'hDEAD_BEEF, 0, 0, 0, 0, 0,  0, 32'h0,         32'h0,         0, 32'h0);
    vt[1]  = mk(1, 0,  32'h0000_0007, 5, 0, 0, 0, 0,  0, 32'hDEAD_BEEF, 32'h0,         0, 32'h0);
    vt[2]  = mk(0, 0,  32'h0,         0, 5, 0, 0, 0,  0, 32'h0,         32'hDEAD_BEEF, 0, 32'h0);
    vt[3]  = mk(1, 9,  32'h1234_5678, 5, 9, 0, 0, 0,  0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 32'h0);
    vt[4]  = mk(0, 0,  32'h0,         9, 0, 1, 1, 3,  0, 32'h1234_5678, 32'h0,         0, 32'h0);
    vt[5]  = mk(0, 0,  32'h0,         3, 0, 1, 0, 0,  0, 32'h0,         32'h0,         1, 32'h0000_0008);
    vt[6]  = mk(1, 3,  32'hAAAA_0003, 3, 0, 1, 0, 0,  0, 32'hAAAA_0003, 32'h0,         0, 32'h0000_0008);
    vt[7]  = mk(0, 0,  32'h0,         3, 0, 0, 0, 0,  0, 32'hAAAA_0003, 32'h0,         0, 32'h0);
    vt[8]  = mk(0, 0,  32'h0,         0, 0, 1, 1, 4,  0, 32'h0,         32'h0,         0, 32'h0);
    vt[9]  = mk(0, 0,  32'h0,         0, 0, 1, 1, 4,  0, 32'h0,         32'h0,         1, 32'h0000_0010);
    vt[10] = mk(1, 4,  32'h0000_0044, 4, 0, 1, 1, 4,  0, 32'h0000_0044, 32'h0,         0, 32'h0000_0010);
    vt[11] = mk(0, 0,  32'h0,         4, 0, 0, 0, 0,  0, 32'h0000_0044, 32'h0,         0, 32'h0000_0010);
    vt[12] = mk(1, 4,  32'h0000_0045, 0, 4, 0, 0, 0,  0, 32'h0,         32'h0000_0045, 0, 32'h0000_0010);
    vt[13] = mk(0, 0,  32'h0,         0, 0, 1, 1, 2,  0, 32'h0,         32'h0,         0, 32'h0);
    vt[14] = mk(0, 0,  32'h0,         0, 0, 1, 1, 7,  0, 32'h0,         32'h0,         0, 32'h0000_0004);
    vt[15] = mk(0, 0,  32'h0,         2, 7, 1, 1, 8,  1, 32'h0,         32'h0,         0, 32'h0000_0084);
    vt[16] = mk(0, 0,  32'h0,         2, 7, 1, 0, 0,  0, 32'h0,         32'h0,         0, 32'h0);
    vt[17] = mk(0, 0,  32'h0,         0, 0, 1, 1, 0,  0, 32'h0,         32'h0,         0, 32'h0);
    vt[18] = mk(0, 0,  32'h0,         0, 0, 0, 0, 0,  0, 32'h0,         32'h0,         0, 32'h0);

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    bus.rs1 = 5'd5;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rs1", bus.rs1_data, 32'h0);
    chk("reset_busy", bus.busy, 32'h0);
    chk("reset_hazard", {31'h0, bus.hazard}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(vt[i]);
      #2;
      chk($sformatf("vec%0d_rs1", i), bus.rs1_data, vt[i].e1);
      chk($sformatf("vec%0d_rs2", i), bus.rs2_data, vt[i].e2);
      chk($sformatf("vec%0d_hazard", i), {31'h0, bus.hazard}, {31'h0, vt[i].eh});
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].eb);
      tick();
    end

    // Randomized traffic against the model; small index range to force collisions
    for (int i = 0; i < 400; i++) begin
      rv = '{default: '0};
      rv.wr  = ($urandom_range(0, 99) < 40);
      rv.rd  = 5'($urandom_range(0, 7));
      rv.wd  = $urandom;
      rv.r1  = 5'($urandom_range(0, 7));
      rv.r2  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      rv.iv  = ($urandom_range(0, 99) < 60);
      rv.iw  = ($urandom_range(0, 99) < 60);
      rv.ird = 5'($urandom_range(0, 7));
      rv.fl  = ($urandom_range(0, 99) < 4);
      drive(rv);
      #2;
      chk($sformatf("rnd%0d_rs1", i), bus.rs1_data, m_read(rv.r1));
      chk($sformatf("rnd%0d_rs2", i), bus.rs2_data, m_read(rv.r2));
      chk($sformatf("rnd%0d_hazard", i), {31'h0, bus.hazard}, {31'h0, m_hazard()});
      chk($sformatf("rnd%0d_busy", i), bus.busy, m_busy_vec());
      tick();
    end

    // Mid-cycle asynchronous reset after writes and a pending producer
    drive(mk(1, 6, 32'h0000_0066, 0, 0, 1, 1, 10, 1'b0, 0, 0, 0, 0));
    tick();
    drive(mk(0, 0, 32'h0, 6, 10, 1, 0, 0, 1'b0, 0, 0, 0, 0));
    #2;
    chk("pre_rst_rs1", bus.rs1_data, 32'h0000_0066);
    chk("pre_rst_busy10", {31'h0, bus.busy[10]}, 32'h1);
    chk("pre_rst_hazard", {31'h0, bus.hazard}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rs1", bus.rs1_data, 32'h0);
    chk("async_rst_busy", bus.busy, 32'h0);
    chk("async_rst_hazard", {31'h0, bus.hazard}, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(mk(0, 0, 32'h0, 6, 5, 0, 0, 0, 1'b0, 0, 0, 0, 0));
    #2;
    chk("post_rst_rs1", bus.rs1_data, 32'h0);
    chk("post_rst_rs2", bus.rs2_data, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
